// File: rtl/jace_ps2_keyboard.sv
// PS/2 (scan-code set 2) receiver and decoder feeding the Jupiter Ace 8x5 key matrix.
// The matrix is read back combinationally through the active-low row/column port.
module jace_ps2_keyboard #(
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [7:0] rows,
   output logic [4:0] kbdcols,
   output logic [7:0] scan_code,
   output logic       scan_strobe
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // Returns {valid, matrix index} where index = row*5 + col.
   function automatic logic [6:0] key_map(input logic ext, input logic [7:0] code);
      logic [6:0] r;
      r = 7'd0;
      if (ext) begin
         case (code)
            8'h14:   r = {1'b1, 6'd1};
            8'h5A:   r = {1'b1, 6'd30};
            default: r = 7'd0;
         endcase
      end else begin
         case (code)
            8'h12, 8'h59: r = {1'b1, 6'd0};
            8'h14: r = {1'b1, 6'd1};
            8'h1A: r = {1'b1, 6'd2};
            8'h22: r = {1'b1, 6'd3};
            8'h21: r = {1'b1, 6'd4};
            8'h1C: r = {1'b1, 6'd5};
            8'h1B: r = {1'b1, 6'd6};
            8'h23: r = {1'b1, 6'd7};
            8'h2B: r = {1'b1, 6'd8};
            8'h34: r = {1'b1, 6'd9};
            8'h15: r = {1'b1, 6'd10};
            8'h1D: r = {1'b1, 6'd11};
            8'h24: r = {1'b1, 6'd12};
            8'h2D: r = {1'b1, 6'd13};
            8'h2C: r = {1'b1, 6'd14};
            8'h16: r = {1'b1, 6'd15};
            8'h1E: r = {1'b1, 6'd16};
            8'h26: r = {1'b1, 6'd17};
            8'h25: r = {1'b1, 6'd18};
            8'h2E: r = {1'b1, 6'd19};
            8'h45: r = {1'b1, 6'd20};
            8'h46: r = {1'b1, 6'd21};
            8'h3E: r = {1'b1, 6'd22};
            8'h3D: r = {1'b1, 6'd23};
            8'h36: r = {1'b1, 6'd24};
            8'h4D: r = {1'b1, 6'd25};
            8'h44: r = {1'b1, 6'd26};
            8'h43: r = {1'b1, 6'd27};
            8'h3C: r = {1'b1, 6'd28};
            8'h35: r = {1'b1, 6'd29};
            8'h5A: r = {1'b1, 6'd30};
            8'h4B: r = {1'b1, 6'd31};
            8'h42: r = {1'b1, 6'd32};
            8'h3B: r = {1'b1, 6'd33};
            8'h33: r = {1'b1, 6'd34};
            8'h29: r = {1'b1, 6'd35};
            8'h3A: r = {1'b1, 6'd36};
            8'h31: r = {1'b1, 6'd37};
            8'h32: r = {1'b1, 6'd38};
            8'h2A: r = {1'b1, 6'd39};
            default: r = 7'd0;
         endcase
      end
      return r;
   endfunction

   function automatic logic odd_parity9(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          brk_q, brk_d, ext_q, ext_d;
   logic [39:0]   matrix_q, matrix_d;
   logic [7:0]    scan_code_q, scan_code_d;
   logic          scan_strobe_q, scan_strobe_d;
   logic          fe_s, timeout_s, accept_s;
   logic [6:0]    map_s;
   logic [4:0]    cols_s;

   assign fe_s      = clk_prev_q & ~clk_s2_q;
   assign timeout_s = (tmo_q == TW'(TIMEOUT_CYCLES));
   assign map_s     = key_map(ext_q, shift_q);

   // State register and all datapath flops; synchronisers idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_q      <= 1'b1;
         clk_s2_q      <= 1'b1;
         clk_prev_q    <= 1'b1;
         dat_s1_q      <= 1'b1;
         dat_s2_q      <= 1'b1;
         state_q       <= ST_IDLE;
         bit_cnt_q     <= 3'd0;
         shift_q       <= 8'h00;
         par_q         <= 1'b0;
         tmo_q         <= '0;
         brk_q         <= 1'b0;
         ext_q         <= 1'b0;
         matrix_q      <= 40'd0;
         scan_code_q   <= 8'h00;
         scan_strobe_q <= 1'b0;
      end else begin
         clk_s1_q      <= ps2_clk;
         clk_s2_q      <= clk_s1_q;
         clk_prev_q    <= clk_s2_q;
         dat_s1_q      <= ps2_data;
         dat_s2_q      <= dat_s1_q;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         par_q         <= par_d;
         tmo_q         <= tmo_d;
         brk_q         <= brk_d;
         ext_q         <= ext_d;
         matrix_q      <= matrix_d;
         scan_code_q   <= scan_code_d;
         scan_strobe_q <= scan_strobe_d;
      end
   end

   // Receiver next-state: timeout outranks any coincident falling edge.
   always_comb begin
      state_d = state_q;
      if (timeout_s) begin
         state_d = ST_IDLE;
      end else if (fe_s) begin
         case (state_q)
            ST_IDLE:   state_d = dat_s2_q ? ST_IDLE : ST_DATA;
            ST_DATA:   state_d = (bit_cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Receiver outputs: shift register, parity capture, timeout counter, byte accept.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      accept_s  = 1'b0;
      if ((state_q == ST_IDLE) || timeout_s || fe_s) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
      if (fe_s && !timeout_s) begin
         case (state_q)
            ST_IDLE: bit_cnt_d = 3'd0;
            ST_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
            ST_PARITY: par_d = dat_s2_q;
            ST_STOP:   accept_s = dat_s2_q & odd_parity9(shift_q, par_q);
            default:   bit_cnt_d = 3'd0;
         endcase
      end else begin
         accept_s = 1'b0;
      end
   end

   // Decoder: prefix flags and matrix updates on each accepted byte.
   always_comb begin
      brk_d         = brk_q;
      ext_d         = ext_q;
      matrix_d      = matrix_q;
      scan_code_d   = scan_code_q;
      scan_strobe_d = accept_s;
      if (accept_s) begin
         scan_code_d = shift_q;
         case (shift_q)
            8'hF0: brk_d = 1'b1;
            8'hE0: ext_d = 1'b1;
            8'hE1: brk_d = brk_q;
            default: begin
               brk_d = 1'b0;
               ext_d = 1'b0;
               // Esc make is a panic button that releases every key.
               if (!ext_q && (shift_q == 8'h76)) begin
                  if (!brk_q) begin
                     matrix_d = 40'd0;
                  end else begin
                     matrix_d = matrix_q;
                  end
               end else if (map_s[6]) begin
                  matrix_d[map_s[5:0]] = ~brk_q;
               end else begin
                  matrix_d = matrix_q;
               end
            end
         endcase
      end else begin
         scan_code_d = scan_code_q;
      end
   end

   // Column read-back: OR of all selected (low) rows, then inverted.
   always_comb begin
      cols_s = 5'd0;
      for (int i = 0; i < 8; i++) begin
         if (!rows[i]) begin
            cols_s = cols_s | matrix_q[i*5 +: 5];
         end else begin
            cols_s = cols_s;
         end
      end
   end

   assign kbdcols     = ~cols_s;
   assign scan_code   = scan_code_q;
   assign scan_strobe = scan_strobe_q;

endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Self-checking bench for jace_ps2_keyboard: bit-banged PS/2 frames, a scoreboard
// of expected scan codes, and direct checks of the key-matrix read-back.
module tb_jace_ps2_keyboard;

   localparam int TMO  = 100;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] rows = 8'hFF;
   logic [4:0] kbdcols;
   logic [7:0] scan_code;
   logic       scan_strobe;

   int         vectors = 0;
   int         miscompares = 0;
   int         strobe_cnt = 0;
   logic [7:0] exp_q[$];

   jace_ps2_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rows(rows), .kbdcols(kbdcols), .scan_code(scan_code), .scan_strobe(scan_strobe)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every strobe must match the oldest outstanding byte.
   always @(negedge clk) begin
      if (scan_strobe === 1'b1) begin
         logic [7:0] e;
         strobe_cnt++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: scan_code=%02h, no byte expected", scan_code);
         end else begin
            e = exp_q.pop_front();
            if (scan_code !== e) begin
               miscompares++;
               $display("FAIL scan_code: got %02h expected %02h", scan_code, e);
            end
         end
      end
   end

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0);
      logic p;
      p = (~^b) ^ bad_par;
      if (!bad_par) exp_q.push_back(b);
      send_bits({1'b1, p, b, 1'b0}, 11);
      repeat (10) @(posedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rows = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (kbdcols !== 5'b11111) begin
         miscompares++; $display("FAIL reset_cols: got %b expected 11111", kbdcols);
      end
      vectors++;
      if (scan_code !== 8'h00 || scan_strobe !== 1'b0) begin
         miscompares++; $display("FAIL reset_scan: got %02h/%b expected 00/0", scan_code, scan_strobe);
      end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (strobe_cnt !== 0) begin
         miscompares++; $display("FAIL reset_release_strobe: got %0d expected 0", strobe_cnt);
      end
   endtask

   task automatic test_make_break;
      int s0;
      s0 = strobe_cnt;
      send_byte(8'h1C);
      rows = 8'hFD; #1;
      vectors++;
      if (kbdcols !== 5'b11110) begin
         miscompares++; $display("FAIL a_make: got %b expected 11110", kbdcols);
      end
      rows = 8'hFF; #1;
      vectors++;
      if (kbdcols !== 5'b11111) begin
         miscompares++; $display("FAIL no_row: got %b expected 11111", kbdcols);
      end
      send_byte(8'hF0);
      send_byte(8'h1C);
      rows = 8'hFD; #1;
      vectors++;
      if (kbdcols !== 5'b11111) begin
         miscompares++; $display("FAIL a_break: got %b expected 11111", kbdcols);
      end
      vectors++;
      if (strobe_cnt - s0 !== 3) begin
         miscompares++; $display("FAIL strobe_count: got %0d expected 3", strobe_cnt - s0);
      end
   endtask

   task automatic test_shift_symshift;
      send_byte(8'h12);
      send_byte(8'h14);
      rows = 8'hFE; #1;
      vectors++;
      if (kbdcols !== 5'b11100) begin
         miscompares++; $display("FAIL shift_sym: got %b expected 11100", kbdcols);
      end
      send_byte(8'hE0);
      send_byte(8'h14);
      send_byte(8'hF0);
      send_byte(8'h12);
      #1;
      vectors++;
      if (kbdcols !== 5'b11101) begin
         miscompares++; $display("FAIL shift_release: got %b expected 11101", kbdcols);
      end
      send_byte(8'hE0);
      send_byte(8'h5A);
      rows = 8'hBF; #1;
      vectors++;
      if (kbdcols !== 5'b11110) begin
         miscompares++; $display("FAIL kp_enter: got %b expected 11110", kbdcols);
      end
   endtask

   task automatic test_multirow_esc;
      send_byte(8'h16);
      send_byte(8'h45);
      rows = 8'hE7; #1;
      vectors++;
      if (kbdcols !== 5'b11110) begin
         miscompares++; $display("FAIL multirow: got %b expected 11110", kbdcols);
      end
      send_byte(8'hF0);
      send_byte(8'h76);
      #1;
      vectors++;
      if (kbdcols !== 5'b11110) begin
         miscompares++; $display("FAIL esc_break: got %b expected 11110", kbdcols);
      end
      send_byte(8'h76);
      rows = 8'h00; #1;
      vectors++;
      if (kbdcols !== 5'b11111) begin
         miscompares++; $display("FAIL esc_clear: got %b expected 11111", kbdcols);
      end
   endtask

   task automatic test_bad_frames;
      int s0;
      s0 = strobe_cnt;
      send_byte(8'h1C, 1'b1);
      rows = 8'hFD; #1;
      vectors++;
      if (kbdcols !== 5'b11111 || strobe_cnt !== s0) begin
         miscompares++;
         $display("FAIL bad_parity: got cols %b strobes %0d expected 11111 / %0d", kbdcols, strobe_cnt, s0);
      end
      send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 6);
      repeat (TMO + 10) @(posedge clk);
      send_byte(8'h29);
      vectors++;
      if (strobe_cnt - s0 !== 1) begin
         miscompares++; $display("FAIL timeout_strobes: got %0d expected 1", strobe_cnt - s0);
      end
      rows = 8'h7F; #1;
      vectors++;
      if (kbdcols !== 5'b11110) begin
         miscompares++; $display("FAIL space_after_timeout: got %b expected 11110", kbdcols);
      end
   endtask

   task automatic test_reset_midseq;
      send_byte(8'h1C);
      send_byte(8'hF0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      rows = 8'h00; #1;
      vectors++;
      if (kbdcols !== 5'b11111 || scan_code !== 8'h00) begin
         miscompares++; $display("FAIL midseq_reset: got %b/%02h expected 11111/00", kbdcols, scan_code);
      end
      repeat (2) @(posedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      send_byte(8'h1C);
      rows = 8'hFD; #1;
      vectors++;
      if (kbdcols !== 5'b11110) begin
         miscompares++; $display("FAIL make_after_reset: got %b expected 11110", kbdcols);
      end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_shift_symshift();
      test_multirow_esc();
      test_bad_frames();
      test_reset_midseq();
      repeat (20) @(posedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL missing_strobes: %0d bytes outstanding, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
